// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_pkg;

   typedef enum logic {
      IDLE,
      ACTIVE
   } spi_target_state_t;

   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   localparam int SPI_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_target_if.sv
// Pin and stream bundle of the SPI target.
interface spi_target_if
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_DATA_WIDTH
);

   logic                  spi_cs_n;
   logic                  spi_sck;
   logic                  spi_mosi;
   logic                  spi_miso;
   logic                  spi_miso_oe;
   logic [DATA_WIDTH-1:0] rx_tdata;
   logic                  rx_tvalid;
   logic                  rx_tready;
   logic [DATA_WIDTH-1:0] tx_tdata;
   logic                  tx_tvalid;
   logic                  tx_tready;
   logic                  overrun;
   logic                  underrun;

   modport slave (
      input  spi_cs_n, spi_sck, spi_mosi,
      input  rx_tready, tx_tdata, tx_tvalid,
      output spi_miso, spi_miso_oe,
      output rx_tdata, rx_tvalid, tx_tready,
      output overrun, underrun
   );

   modport master (
      output spi_cs_n, spi_sck, spi_mosi,
      output rx_tready, tx_tdata, tx_tvalid,
      input  spi_miso, spi_miso_oe,
      input  rx_tdata, rx_tvalid, tx_tready,
      input  overrun, underrun
   );

endinterface

// File: rtl/spi_target_sync_edge.sv
// Multi-flop synchroniser with edge detection on the synced level.
module sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, rx/tx AXI-stream words.
module spi_target
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] IDLE_TX = '0
) (
   input logic         clk,
   input logic         reset,
   spi_target_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   spi_target_state_t     state_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic                  reload_q;
   logic [DATA_WIDTH-1:0] rx_shift_q;
   logic [DATA_WIDTH-1:0] tx_shift_q;
   logic [DATA_WIDTH-1:0] rx_tdata_q;
   logic                  rx_tvalid_q;
   logic                  tx_tready_q;
   logic                  overrun_q;
   logic                  underrun_q;

   logic sck_rise, sck_fall, sck_lvl_unused;
   logic cs_rise, cs_fall, cs_lvl_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   logic [DATA_WIDTH-1:0] rx_word_d;
   logic [DATA_WIDTH-1:0] tx_word_d;
   logic                  last_bit;

   sync_edge #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (SPI_CPOL)
   ) u_sck (
      .clk     (clk),
      .reset   (reset),
      .d_i     (bus.spi_sck),
      .level_o (sck_lvl_unused),
      .rise_o  (sck_rise),
      .fall_o  (sck_fall)
   );

   sync_edge #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_cs (
      .clk     (clk),
      .reset   (reset),
      .d_i     (bus.spi_cs_n),
      .level_o (cs_lvl_unused),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   sync_edge #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b0)
   ) u_mosi (
      .clk     (clk),
      .reset   (reset),
      .d_i     (bus.spi_mosi),
      .level_o (mosi_s),
      .rise_o  (mosi_rise_unused),
      .fall_o  (mosi_fall_unused)
   );

   assign rx_word_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
   assign tx_word_d = bus.tx_tvalid ? bus.tx_tdata : IDLE_TX;
   assign last_bit  = bit_cnt_q == CNT_W'(DATA_WIDTH-1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         reload_q    <= 1'b0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         rx_tdata_q  <= '0;
         rx_tvalid_q <= 1'b0;
         tx_tready_q <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         tx_tready_q <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
         if (rx_tvalid_q && bus.rx_tready) begin
            rx_tvalid_q <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_q     <= ACTIVE;
                  bit_cnt_q   <= '0;
                  reload_q    <= 1'b0;
                  tx_shift_q  <= tx_word_d;
                  tx_tready_q <= bus.tx_tvalid;
                  underrun_q  <= ~bus.tx_tvalid;
               end
            end
            ACTIVE: begin
               // Deselect beats any sck edge seen in the same cycle.
               if (cs_rise) begin
                  state_q   <= IDLE;
                  bit_cnt_q <= '0;
                  reload_q  <= 1'b0;
               end else if (sck_rise) begin
                  rx_shift_q <= rx_word_d;
                  if (last_bit) begin
                     bit_cnt_q <= '0;
                     if (!rx_tvalid_q || bus.rx_tready) begin
                        rx_tdata_q  <= rx_word_d;
                        rx_tvalid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                     tx_shift_q  <= tx_word_d;
                     tx_tready_q <= bus.tx_tvalid;
                     underrun_q  <= ~bus.tx_tvalid;
                     reload_q    <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
               end else if (sck_fall) begin
                  // The freshly loaded word must keep its MSB for the next rise.
                  if (reload_q) begin
                     reload_q <= 1'b0;
                  end else begin
                     tx_shift_q <= tx_shift_q << 1;
                  end
               end
            end
         endcase
      end
   end

   assign bus.spi_miso_oe = state_q == ACTIVE;
   assign bus.spi_miso    = (state_q == ACTIVE) &
                            tx_shift_q[DATA_WIDTH-1];
   assign bus.rx_tdata    = rx_tdata_q;
   assign bus.rx_tvalid   = rx_tvalid_q;
   assign bus.tx_tready   = tx_tready_q;
   assign bus.overrun     = overrun_q;
   assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Randomised scoreboard bench for the SPI mode-0 target.
module tb_spi_target;

   logic clk = 1'b0;
   logic reset;

   spi_target_if #(.DATA_WIDTH(8)) bus ();

   spi_target #(
      .DATA_WIDTH  (8),
      .SYNC_STAGES (2),
      .IDLE_TX     (8'h00)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_tready = 0;
   int n_under = 0;
   int n_over = 0;
   int exp_tready = 0;
   int exp_under = 0;
   int exp_over = 0;

   logic [7:0] rx_exp[$];
   logic [7:0] txq[$];
   logic [7:0] mo[4];
   logic [7:0] tw[4];
   int         ntx;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Monitor: pulse counters, rx scoreboard, tx stream source.
   always @(negedge clk) begin
      if (bus.tx_tready) n_tready++;
      if (bus.underrun) n_under++;
      if (bus.overrun) n_over++;
      if (bus.rx_tvalid && bus.rx_tready) begin
         if (rx_exp.size() == 0) begin
            chk("rx_unexpected", {24'h0, bus.rx_tdata}, 32'hFFFF_FFFF);
         end else begin
            chk("rx_word", {24'h0, bus.rx_tdata},
                {24'h0, rx_exp.pop_front()});
         end
      end
      if (bus.tx_tready && txq.size() > 0) void'(txq.pop_front());
      bus.tx_tvalid = txq.size() > 0;
      bus.tx_tdata  = (txq.size() > 0) ? txq[0] : 8'h00;
   end

   task automatic chk_counts();
      chk("tready_cnt", n_tready, exp_tready);
      chk("underrun_cnt", n_under, exp_under);
      chk("overrun_cnt", n_over, exp_over);
   endtask

   // Every word start (select, or each completed word) loads one tx word.
   task automatic xfer(input int nfull, input int pbits, input bit hold);
      logic [7:0] got;
      logic [7:0] em;
      int nb;
      int nld;
      int npop;
      for (int i = 0; i < ntx; i++) txq.push_back(tw[i]);
      for (int w = 0; w < nfull; w++)
         if (!hold || w == 0) rx_exp.push_back(mo[w]);
      if (hold && nfull > 1) exp_over += nfull - 1;
      nld  = nfull + 1;
      npop = (ntx < nld) ? ntx : nld;
      exp_tready += npop;
      exp_under  += nld - npop;
      tick(2);
      bus.spi_cs_n = 1'b0;
      tick(8);
      for (int w = 0; w <= nfull; w++) begin
         nb  = (w < nfull) ? 8 : pbits;
         got = 8'h00;
         for (int b = 0; b < nb; b++) begin
            bus.spi_mosi = mo[w][7-b];
            tick(4);
            bus.spi_sck = 1'b1;
            got = {got[6:0], bus.spi_miso};
            if (b == 0) chk("miso_oe_active", bus.spi_miso_oe, 1);
            tick(4);
            bus.spi_sck = 1'b0;
         end
         if (w < nfull) begin
            em = (w < ntx) ? tw[w] : 8'h00;
            chk("miso_word", got, em);
         end
      end
      tick(4);
      bus.spi_cs_n = 1'b1;
      tick(8);
      txq.delete();
      tick(2);
      chk("miso_idle", {bus.spi_miso_oe, bus.spi_miso}, 0);
      chk_counts();
   endtask

   initial begin
      int nf;
      int pb;
      reset         = 1'b1;
      bus.spi_cs_n  = 1'b1;
      bus.spi_sck   = 1'b0;
      bus.spi_mosi  = 1'b0;
      bus.rx_tready = 1'b1;
      tick(3);
      chk("reset_outs",
          {bus.spi_miso, bus.spi_miso_oe, bus.rx_tdata, bus.rx_tvalid,
           bus.tx_tready, bus.overrun, bus.underrun}, 0);
      reset = 1'b0;
      tick(4);

      // Single word, tx A5 against mosi 3C.
      mo[0] = 8'h3C; tw[0] = 8'hA5; ntx = 1;
      xfer(1, 0, 0);

      // Two-word burst.
      mo[0] = 8'hDE; mo[1] = 8'hAD;
      tw[0] = 8'h12; tw[1] = 8'h34; ntx = 2;
      xfer(2, 0, 0);

      // No tx data: idle word shifted, underrun.
      mo[0] = 8'h77; ntx = 0;
      xfer(1, 0, 0);

      // Held rx: second word overruns.
      bus.rx_tready = 1'b0;
      mo[0] = 8'h01; mo[1] = 8'h02; ntx = 0;
      xfer(2, 0, 1);
      chk("rx_hold_data", bus.rx_tdata, 8'h01);
      chk("rx_hold_valid", bus.rx_tvalid, 1);
      bus.rx_tready = 1'b1;
      tick(4);
      chk("rx_drain", rx_exp.size(), 0);

      // Aborted partial word, then a full one.
      mo[0] = 8'hFF; ntx = 0;
      xfer(0, 5, 0);
      mo[0] = 8'h81; ntx = 0;
      xfer(1, 0, 0);

      // Reset in the middle of a word.
      bus.spi_cs_n = 1'b0;
      exp_under += 1;
      tick(8);
      for (int b = 0; b < 3; b++) begin
         bus.spi_mosi = 1'b1;
         tick(4);
         bus.spi_sck = 1'b1;
         tick(4);
         bus.spi_sck = 1'b0;
      end
      reset = 1'b1;
      tick(1);
      chk("reset_mid_outs",
          {bus.spi_miso, bus.spi_miso_oe, bus.rx_tdata, bus.rx_tvalid,
           bus.tx_tready, bus.overrun, bus.underrun}, 0);
      bus.spi_cs_n = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(8);
      mo[0] = 8'h5A; ntx = 0;
      xfer(1, 0, 0);
      chk("rx_after_reset", bus.rx_tdata, 8'h5A);

      // Random transfers.
      for (int t = 0; t < 20; t++) begin
         nf = $urandom_range(3, 0);
         pb = $urandom_range(7, 0);
         if (nf == 0 && pb == 0) nf = 1;
         for (int i = 0; i < 4; i++) begin
            mo[i] = 8'($urandom);
            tw[i] = 8'($urandom);
         end
         ntx = $urandom_range(nf + 1, 0);
         xfer(nf, pb, 0);
      end

      tick(4);
      chk("rx_queue_empty", rx_exp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
SPI mode-0 target (responder) that is the far end of the accelerometer-style SPI initiator bus, used in simulation as an accelerometer stand-in and on hardware as a loopback/bridge target.
- Oversamples the asynchronous sck/cs_n/mosi pins in the clk domain.
- Deserialises received words onto an AXI-stream source.
- Serialises words taken from an AXI-stream sink onto miso.
- Sits beside the UART bridge, so host bytes can be fed back as SPI responses.

Parameters:
DATA_WIDTH, 8, bits per SPI word (MSB first).
SYNC_STAGES, 2, flip-flop stages per input synchroniser (minimum 2).
IDLE_TX, 8'h00, word shifted out when tx stream has no data at word start.

Ports:
clk  input  1  system clock; sck must be at most clk/8.
reset  input  1  asynchronous, active-high reset.
spi_cs_n  input  1  chip select from initiator, active low.
spi_sck  input  1  serial clock from initiator, idle low.
spi_mosi  input  1  initiator-to-target data.
spi_miso  output  1  target-to-initiator data.
spi_miso_oe  output  1  high while selected; pad tristates miso when low.
rx_tdata  output  DATA_WIDTH  received word.
rx_tvalid  output  1  rx word available.
rx_tready  input  1  downstream accepts rx word.
tx_tdata  input  DATA_WIDTH  next word to send.
tx_tvalid  input  1  tx word offered.
tx_tready  output  1  one-cycle pop pulse when a tx word is loaded.
overrun  output  1  one-cycle pulse: completed rx word dropped because rx_tvalid still high.
underrun  output  1  one-cycle pulse: IDLE_TX substituted because tx_tvalid low at word load.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, bit counter 0, shift registers 0, synchronisers preset to cs_n=1, sck=0.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised sck (rise = prev 0, now 1; fall = prev 1, now 0) and on synchronised cs_n.
- State IDLE:
  - miso_oe=0, miso=0.
  - On cs_n falling edge, load a tx word and go to ACTIVE.
  - Load rule: if tx_tvalid, take tx_tdata and pulse tx_tready for 1 cycle; else take IDLE_TX and pulse underrun.
- State ACTIVE:
  - miso_oe=1, miso = tx_shift[DATA_WIDTH-1].
  - sck rise: rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi}; bit_cnt increments.
  - sck rise at bit_cnt == DATA_WIDTH-1 (word complete):
    - If !rx_tvalid: rx_tdata <= assembled word, rx_tvalid <= 1.
    - Else: keep the old word and pulse overrun.
    - bit_cnt wraps to 0.
    - Next tx word is loaded using the load rule and a reload flag is set.
  - sck fall: if reload flag, clear it and do not shift; else tx_shift <= tx_shift << 1.
  - cs_n rising edge: go to IDLE in the same cycle.
    - A partial rx word is discarded; no rx_tvalid, no overrun.
    - bit_cnt <= 0 and reload flag cleared.
    - A tx word already popped is consumed, not re-offered.
  - cs_n rising and sck edge in the same synchronised cycle: cs_n wins; the sck edge is ignored.
- rx stream: rx_tvalid holds until rx_tvalid && rx_tready, then clears the next cycle. A new word completing in the same cycle as acceptance is captured, not an overrun.
- Latency:
  - rx_tvalid rises SYNC_STAGES+1 clk after the final sck rising pin edge.
  - miso MSB is valid SYNC_STAGES+1 clk after cs_n falls; the initiator must allow at least that setup before the first sck rise.
- Reset mid-transfer: abort immediately to IDLE and outputs to reset values. A transfer in progress is not resumed until the next cs_n falling edge.

Decomposition:
- Package spi_pkg:
  - typedef enum {IDLE, ACTIVE} spi_target_state_t
  - SPI_MODE0 constants (CPOL=0, CPHA=0)
  - default DATA_WIDTH localparam
- Sub-module sync_edge: parameterised SYNC_STAGES synchroniser with reset preset value, outputs level, rise and fall. Instantiated for sck and cs_n; mosi uses the synchroniser only.

Test Plan:
- tx_tvalid=1, tx_tdata=8'hA5; initiator sends 8'h3C at sck=clk/8 -> miso bits 1,0,1,0,0,1,0,1; rx_tdata=8'h3C with rx_tvalid; tx_tready pulses once.
- Two-word burst under one cs_n, tx queue {8'h12,8'h34}, mosi {8'hDE,8'hAD}, rx_tready=1 -> miso 8'h12 then 8'h34; rx words 8'hDE then 8'hAD; no reload glitch between words.
- tx_tvalid=0 at cs_n fall -> miso shifts IDLE_TX=8'h00; underrun pulses once; miso_oe=1 only while selected.
- rx_tready=0, send 8'h01 then 8'h02 -> rx_tdata stays 8'h01; overrun pulses once at second word completion.
- cs_n deasserted after 5 bits of 8'hFF, then full 8'h81 -> only 8'h81 delivered; bit_cnt restarted.
- reset asserted after 3 bits, released, new transfer 8'h5A -> outputs 0 during reset; rx_tdata=8'h5A afterwards.
